// File: rtl/m_axi_ctrl.sv
// Single-outstanding, single-beat AXI initiator that turns one command into one AXI read or write.
// Optional watchdog is enabled by defining M_AXI_CTRL_TIMEOUT_EN.
module m_axi_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        areset,

  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [3:0]  cmd_id_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_wstrb_i,

  output logic        rsp_valid_o,
  output logic        rsp_write_o,
  output logic [3:0]  rsp_id_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_resp_o,
  output logic        rsp_timeout_o,

  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,

  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,

  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,

  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,

  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [2:0]  state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        write_q, write_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        bready_q, bready_d;
  logic        rready_q, rready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [3:0]  rsp_id_q, rsp_id_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;

  logic aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s;
  logic aw_all_s, w_all_s;

`ifdef M_AXI_CTRL_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        timeout_s;
`endif

  assign aw_hs_s  = awvalid_q & awready_i;
  assign w_hs_s   = wvalid_q & wready_i;
  assign ar_hs_s  = arvalid_q & arready_i;
  assign b_hs_s   = bready_q & bvalid_i;
  assign r_hs_s   = rready_q & rvalid_i;
  assign aw_all_s = aw_done_q | aw_hs_s;
  assign w_all_s  = w_done_q | w_hs_s;

`ifdef M_AXI_CTRL_TIMEOUT_EN
  assign timeout_s = (state_q != S_IDLE) && (cnt_q == TO_LAST);
`endif

  // Next-state, channel valids and response capture
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    write_d     = write_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef M_AXI_CTRL_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          id_d      = cmd_id_i;
          addr_d    = cmd_addr_i;
          wdata_d   = cmd_wdata_i;
          wstrb_d   = cmd_wstrb_i;
          write_d   = cmd_write_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write_i) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_REQ;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently; each valid drops after its own handshake
        if (aw_hs_s) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (w_hs_s) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (aw_all_s && w_all_s) begin
          state_d = S_WR_RESP;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_WR_RESP: begin
        if (b_hs_s) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_id_d    = id_q;
          rsp_resp_d  = (bid_i == id_q) ? bresp_i : RESP_SLVERR;
`ifdef M_AXI_CTRL_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end else begin
          state_d = S_WR_RESP;
        end
      end
      S_RD_REQ: begin
        if (ar_hs_s) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_RESP;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_RESP: begin
        if (r_hs_s) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_id_d    = id_q;
          rsp_rdata_d = rdata_i;
          rsp_resp_d  = ((rid_i == id_q) && rlast_i) ? rresp_i : RESP_SLVERR;
`ifdef M_AXI_CTRL_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end else begin
          state_d = S_RD_RESP;
        end
      end
      default: begin
        state_d   = S_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
      end
    endcase

`ifdef M_AXI_CTRL_TIMEOUT_EN
    // Watchdog expiry overrides whatever the channel logic decided this cycle
    if (timeout_s) begin
      state_d       = S_IDLE;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_write_d   = write_q;
      rsp_id_d      = id_q;
      rsp_resp_d    = RESP_DECERR;
      rsp_timeout_d = 1'b1;
    end else begin
      rsp_timeout_d = rsp_timeout_d;
    end
`endif

    cmd_ready_d = (state_d == S_IDLE);
    bready_d    = (state_d == S_WR_RESP);
    rready_d    = (state_d == S_RD_RESP);
  end

`ifdef M_AXI_CTRL_TIMEOUT_EN
  // Watchdog counter: cleared on every state change, counts while busy
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (state_q != S_IDLE) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = 16'd0;
    end
  end

  // Watchdog state registers
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      cnt_q         <= 16'd0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  // Main state, command payload and output registers
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= S_IDLE;
      id_q        <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      write_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_id_q    <= 4'd0;
      rsp_rdata_q <= 32'd0;
      rsp_resp_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      cmd_ready_q <= cmd_ready_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign awid_o      = id_q;
  assign awaddr_o    = addr_q;
  assign awvalid_o   = awvalid_q;
  assign wid_o       = id_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign wlast_o     = wvalid_q;
  assign wvalid_o    = wvalid_q;
  assign bready_o    = bready_q;
  assign arid_o      = id_q;
  assign araddr_o    = addr_q;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_write_o = rsp_write_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_resp_o  = rsp_resp_q;

endmodule

// File: doc/m_axi_ctrl.md
M_AXI_CTRL -- requirements
Module: m_axi_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 256, giving the watchdog limit in clk cycles; it is used only under M_AXI_CTRL_TIMEOUT_EN and is legal from 2 to 65535.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port areset, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have cmd_valid_i in 1, cmd_ready_o out 1, cmd_write_i in 1 (1=write, 0=read) as the command handshake.
REQ-005 The block SHALL have command payload inputs cmd_id_i 4, cmd_addr_i 32, cmd_wdata_i 32 and cmd_wstrb_i 4.
REQ-006 The block SHALL have result outputs: rsp_valid_o 1, rsp_write_o 1, rsp_id_o 4, rsp_rdata_o 32, rsp_resp_o 2 and rsp_timeout_o 1.
REQ-007 The block SHALL have AXI write-address ports: awid_o out 4, awaddr_o out 32, awvalid_o out 1, awready_i in 1.
REQ-008 The block SHALL have AXI write-data ports: wid_o out 4, wdata_o out 32, wstrb_o out 4, wlast_o out 1, wvalid_o out 1, wready_i in 1.
REQ-009 The block SHALL have AXI write-response ports: bid_i in 4, bresp_i in 2, bvalid_i in 1, bready_o out 1.
REQ-010 The block SHALL have AXI read-address ports arid_o out 4, araddr_o out 32, arvalid_o out 1, arready_i in 1, and read-data ports rid_i in 4, rdata_i in 32, rresp_i in 2, rlast_i in 1, rvalid_i in 1, rready_o out 1.

Function
REQ-011 The block SHALL be a single-outstanding, single-beat AXI initiator with states IDLE, WR_REQ, WR_RESP, RD_REQ and RD_RESP.
REQ-012 The block SHALL drive cmd_ready_o=1 only in IDLE and accept a command on cmd_valid_i&&cmd_ready_o, registering id, addr, wdata, wstrb and the write flag.
REQ-013 On accepting a write, the block SHALL go to WR_REQ and assert awvalid_o and wvalid_o together the next cycle, with wlast_o=1 and awid_o=wid_o=id.
REQ-014 In WR_REQ, awvalid_o and wvalid_o SHALL each drop the cycle after their own handshake, independently, and all AW/W payloads SHALL stay stable while the matching valid is high.
REQ-015 When both the AW and W handshakes are done (same cycle or different cycles), the block SHALL go to WR_RESP and drive bready_o=1 only in that state.
REQ-016 On bvalid_i&&bready_o, the block SHALL return to IDLE and, on the next cycle only, pulse rsp_valid_o with rsp_write_o=1, rsp_id_o=id and rsp_resp_o=bresp_i, or 2'b10 if bid_i differs from id.
REQ-017 On accepting a read, the block SHALL go to RD_REQ and assert arvalid_o the next cycle, dropping it after the handshake and moving to RD_RESP with rready_o=1 only in that state.
REQ-018 On rvalid_i&&rready_o, the block SHALL return to IDLE and pulse rsp_valid_o for one cycle with rsp_write_o=0, rsp_rdata_o=rdata_i and rsp_resp_o=rresp_i, or 2'b10 if rid_i differs from id or rlast_i=0.
REQ-019 The rsp_* payload SHALL hold its last value while rsp_valid_o=0; there is no backpressure on rsp_valid_o.
REQ-020 bvalid_i and rvalid_i SHALL be ignored outside WR_RESP and RD_RESP respectively, and a cmd_valid_i held high during the rsp_valid_o pulse SHALL be accepted on that same cycle.

Reset
REQ-021 While areset=0, the block SHALL be in IDLE with every valid/ready output 0 except cmd_ready_o=1, all payload outputs 0, and the watchdog counter at 0.
REQ-022 Reset asserted mid-transaction SHALL abort it immediately with no rsp_valid_o pulse, and the first command after release SHALL be accepted normally.

Configuration
REQ-023 With M_AXI_CTRL_TIMEOUT_EN defined, a 16-bit counter SHALL clear on every state entry and count in non-IDLE states; on reaching TIMEOUT_CYCLES-1 the block SHALL drop all AXI valid/ready outputs, go to IDLE, and pulse rsp_valid_o with rsp_resp_o=2'b11 and rsp_timeout_o=1.
REQ-024 Without M_AXI_CTRL_TIMEOUT_EN, the block SHALL wait indefinitely, rsp_timeout_o SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-025 The bench SHALL cover a write with id=3, addr=0x4, data=0xDEADBEEF, strb=0xF and awready/wready high: AW and W handshake on cycle 1, B with bresp=0 and bid=3 on cycle 3 -> rsp_valid_o on cycle 4 with resp=0 and write=1.
REQ-026 The bench SHALL cover a write with wready delayed 5 cycles after awready: awvalid_o drops after 1 cycle, wvalid_o stays high 6 cycles, bready_o rises only after the W handshake, and wdata_o stays stable throughout.
REQ-027 The bench SHALL cover a read of addr=0x8 with id=5 returning rdata=0x12345678, rid=5, rlast=1 -> rsp_rdata_o=0x12345678 and resp=0; the same read with rid=6 -> resp=2'b10.
REQ-028 The bench SHALL cover areset dropping while in WR_RESP -> all valid outputs 0 at once, no rsp_valid_o, and a following read completing correctly.
REQ-029 The bench SHALL cover, with the macro defined and TIMEOUT_CYCLES=16, a read with arready tied to 0 -> arvalid_o drops and rsp_valid_o pulses with resp=2'b11 and timeout=1, 16 cycles after arvalid_o rises; without the macro, arvalid_o stays high for 1000 cycles.
